// File: rtl/adc_pkg.sv
// Shared definitions for the ADC scan master and the ADC responder model:
// scan FSM states, per-channel step encoding and the target register map.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESULT = 2'd3
  } scan_state_e;

  // One APB transfer per step; a channel walks AMUX -> TRIGGER -> STATUS* -> DATA.
  typedef enum logic [1:0] {
    STEP_AMUX    = 2'd0,
    STEP_TRIGGER = 2'd1,
    STEP_STATUS  = 2'd2,
    STEP_DATA    = 2'd3
  } scan_step_e;

  localparam logic [11:0] ADC_STATUS_ADDR  = 12'h000;
  localparam logic [11:0] ADC_AMUX_ADDR    = 12'h00C;
  localparam logic [11:0] ADC_TRIGGER_ADDR = 12'h010;
  localparam logic [11:0] ADC_DATA_ADDR    = 12'h014;

  function automatic logic [11:0] step_addr(input scan_step_e step);
    logic [11:0] addr;
    case (step)
      STEP_AMUX:    addr = ADC_AMUX_ADDR;
      STEP_TRIGGER: addr = ADC_TRIGGER_ADDR;
      STEP_STATUS:  addr = ADC_STATUS_ADDR;
      default:      addr = ADC_DATA_ADDR;
    endcase
    return addr;
  endfunction

  function automatic logic step_is_write(input scan_step_e step);
    return (step == STEP_AMUX) || (step == STEP_TRIGGER);
  endfunction

endpackage

// File: rtl/adc_scan_timer.sv
// Watchdog counters for the scan master: one counts ACCESS cycles spent
// waiting for PREADY, the other counts STATUS reads that came back not done.
// Each "hit" flag is high while the current event is the LIMIT-th one, so the
// master can abort on that same cycle.
module adc_scan_timer #(
  parameter int WAIT_LIMIT = 1023,
  parameter int POLL_LIMIT = 255
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic wait_clr_i,
  input  logic wait_inc_i,
  input  logic poll_clr_i,
  input  logic poll_inc_i,
  output logic wait_hit_o,
  output logic poll_hit_o
);

  localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam int POLL_W = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT + 1) : 1;

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;

  assign wait_hit_o = (wait_cnt_q == WAIT_W'(WAIT_LIMIT - 1));
  assign poll_hit_o = (poll_cnt_q == POLL_W'(POLL_LIMIT - 1));

  // Next count: clear wins, and a counter never runs past its limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    poll_cnt_d = poll_cnt_q;
    if (wait_clr_i)
      wait_cnt_d = '0;
    else if (wait_inc_i && !wait_hit_o)
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    if (poll_clr_i)
      poll_cnt_d = '0;
    else if (poll_inc_i && !poll_hit_o)
      poll_cnt_d = poll_cnt_q + POLL_W'(1);
  end

  // Counter registers, cleared asynchronously with the bus reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_q <= '0;
      poll_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

endmodule

// File: rtl/adc_scan_master.sv
// APB master that scans NUM_CH ADC channels: for each channel it selects the
// mux, triggers a conversion, polls STATUS until done, reads DATA and offers
// the sample (or an error) on a valid/ready result port.
module adc_scan_master
  import adc_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 8,
  parameter int POLL_LIMIT = 255,
  parameter int WAIT_LIMIT = 1023
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  start,
  output logic                  busy,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2:0]            res_ch,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_err
);

  scan_state_e           state_q, state_d;
  scan_step_e            step_q, step_d;
  logic [2:0]            ch_q, ch_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_err_q, res_err_d;

  logic wait_clr, wait_inc, poll_clr, poll_inc;
  logic wait_hit, poll_hit;

  adc_scan_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .POLL_LIMIT (POLL_LIMIT)
  ) u_timer (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .wait_clr_i (wait_clr),
    .wait_inc_i (wait_inc),
    .poll_clr_i (poll_clr),
    .poll_inc_i (poll_inc),
    .wait_hit_o (wait_hit),
    .poll_hit_o (poll_hit)
  );

  // Scan sequencing: step progression, aborts and the result handshake.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    ch_d       = ch_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    wait_clr   = 1'b1;
    wait_inc   = 1'b0;
    // The poll count spans all STATUS reads of one channel only.
    poll_clr   = (step_q != STEP_STATUS) || (state_q == ST_IDLE) || (state_q == ST_RESULT);
    poll_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ch_d    = 3'd0;
          step_d  = STEP_AMUX;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: state_d = ST_ACCESS;

      ST_ACCESS: begin
        wait_clr = 1'b0;
        if (PREADY) begin
          wait_clr = 1'b1;
          if (PSLVERR) begin
            res_err_d  = 1'b1;
            res_data_d = '0;
            state_d    = ST_RESULT;
          end else begin
            case (step_q)
              STEP_AMUX: begin
                step_d  = STEP_TRIGGER;
                state_d = ST_SETUP;
              end
              STEP_TRIGGER: begin
                step_d  = STEP_STATUS;
                state_d = ST_SETUP;
              end
              STEP_STATUS: begin
                if (PRDATA[0]) begin
                  step_d  = STEP_DATA;
                  state_d = ST_SETUP;
                end else begin
                  poll_inc = 1'b1;
                  if (poll_hit) begin
                    res_err_d  = 1'b1;
                    res_data_d = '0;
                    state_d    = ST_RESULT;
                  end else begin
                    state_d = ST_SETUP;
                  end
                end
              end
              default: begin
                res_data_d = PRDATA;
                res_err_d  = 1'b0;
                state_d    = ST_RESULT;
              end
            endcase
          end
        end else begin
          wait_inc = 1'b1;
          if (wait_hit) begin
            res_err_d  = 1'b1;
            res_data_d = '0;
            state_d    = ST_RESULT;
          end
        end
      end

      default: begin
        if (res_ready) begin
          if (ch_q == 3'(NUM_CH - 1)) begin
            state_d = ST_IDLE;
          end else begin
            ch_d    = ch_q + 3'd1;
            step_d  = STEP_AMUX;
            state_d = ST_SETUP;
          end
        end
      end
    endcase
  end

  // APB request lines decode straight from state/step so they are stable
  // from SETUP through the end of ACCESS and zero otherwise.
  always_comb begin
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    if ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) begin
      PSEL    = 1'b1;
      PENABLE = (state_q == ST_ACCESS);
      PWRITE  = step_is_write(step_q);
      PADDR   = ADDR_WIDTH'(step_addr(step_q));
      case (step_q)
        STEP_AMUX:    PWDATA = DATA_WIDTH'(ch_q);
        STEP_TRIGGER: PWDATA = DATA_WIDTH'(1);
        default:      PWDATA = '0;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_RESULT);
  assign res_ch    = res_valid ? ch_q : 3'd0;
  assign res_data  = res_valid ? res_data_q : '0;
  assign res_err   = res_valid ? res_err_q : 1'b0;

  // State registers; reset is asynchronous so a scan stops mid-transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      step_q     <= STEP_AMUX;
      ch_q       <= 3'd0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      ch_q       <= ch_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

endmodule
